// File: rtl/vdb_hex_display.sv
// vdb_hex_display: register-mapped seven-segment controller with static or scanned outputs,
// per-digit hex/raw decode, blink and blank.
module vdb_hex_display #(
    parameter int DIGITS     = 6,
    parameter int MUX_MODE   = 0,
    parameter int ACTIVE_LOW = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [3:0]            addr_i,
    input  logic [7:0]            wdata_i,
    output logic                  ack_o,
    output logic [7:0]            rdata_o,
    output logic [DIGITS*8-1:0]   hex_o,
    output logic [7:0]            seg_o,
    output logic [DIGITS-1:0]     dig_sel_o
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [7:0] OFF = ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] OFF_SEL = ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [DIGITS*8-1:0] OFF_HEX = ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef enum logic {DRIVE, GAP} state_t;

    logic [7:0]           data [DIGITS];
    logic [DIGITS-1:0]    raw, blink, blank;
    logic                 hidden;
    logic [BW-1:0]        blink_cnt;
    logic [SW-1:0]        scan_cnt;
    logic [IW-1:0]        idx;
    state_t               state;
    logic [7:0]           pat [DIGITS];
    logic [7:0]           rd_val, cur;
    logic [DIGITS*8-1:0]  hex_nxt;
    logic [DIGITS-1:0]    onehot;

    // pat holds the active-high visible pattern of each digit; polarity is applied at the outputs
    always_comb begin
        pat = '{default: 8'h00};
        rd_val = 8'h00;
        cur = 8'h00;
        hex_nxt = '0;
        onehot = DIGITS'(1) << idx;
        for (int n = 0; n < DIGITS; n++) begin
            pat[n] = (!blank[n] && !(blink[n] && hidden)) ?
                     (raw[n] ? data[n] : {data[n][7], HEX[data[n][3:0]]}) : 8'h00;
            hex_nxt[8*n +: 8] = ACTIVE_LOW != 0 ? ~pat[n] : pat[n];
            if (addr_i == 4'(n)) rd_val = data[n];
            if (idx == IW'(n)) cur = pat[n];
        end
        if (addr_i == 4'(DIGITS)) rd_val = 8'(raw);
        if (addr_i == 4'(DIGITS + 1)) rd_val = 8'(blink);
        if (addr_i == 4'(DIGITS + 2)) rd_val = 8'(blank);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < DIGITS; n++) data[n] <= 8'h00;
            raw <= '0;
            blink <= '0;
            blank <= '1;
            ack_o <= 1'b0;
            rdata_o <= 8'h00;
        end else begin
            ack_o <= req_i;
            rdata_o <= (req_i && !we_i) ? rd_val : 8'h00;
            if (req_i && we_i) begin
                for (int n = 0; n < DIGITS; n++) if (addr_i == 4'(n)) data[n] <= wdata_i;
                if (addr_i == 4'(DIGITS)) raw <= wdata_i[DIGITS-1:0];
                if (addr_i == 4'(DIGITS + 1)) blink <= wdata_i[DIGITS-1:0];
                if (addr_i == 4'(DIGITS + 2)) blank <= wdata_i[DIGITS-1:0];
            end
        end
    end

    // Each scan slot is SCAN_DIV-1 DRIVE cycles followed by one dark GAP cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= DRIVE;
            idx <= '0;
            scan_cnt <= '0;
            hidden <= 1'b0;
            blink_cnt <= '0;
            hex_o <= OFF_HEX;
            seg_o <= OFF;
            dig_sel_o <= OFF_SEL;
        end else begin
            blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + BW'(1);
            if (blink_cnt == BW'(BLINK_DIV - 1)) hidden <= ~hidden;
            hex_o <= MUX_MODE != 0 ? OFF_HEX : hex_nxt;
            seg_o <= (MUX_MODE != 0 && state == DRIVE) ? (ACTIVE_LOW != 0 ? ~cur : cur) : OFF;
            dig_sel_o <= (MUX_MODE != 0 && state == DRIVE) ? (ACTIVE_LOW != 0 ? ~onehot : onehot) : OFF_SEL;
            case (state)
                DRIVE: begin
                    scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 2)) ? '0 : scan_cnt + SW'(1);
                    if (scan_cnt == SW'(SCAN_DIV - 2)) state <= GAP;
                end
                default: begin
                    state <= DRIVE;
                    idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vdb_hex_display.sv
// tb_vdb_hex_display: static (6 digits, active-low) and scanned (4 digits, active-high) instances
// checked against a register/timing model derived from edge counts since reset release.
module tb_vdb_hex_display;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        ack_s, ack_m;
    logic [7:0]  rd_s, rd_m, seg_s, seg_m;
    logic [47:0] hex_s;
    logic [31:0] hex_m;
    logic [5:0]  sel_s;
    logic [3:0]  sel_m;
    int          total = 0, bad = 0, k = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] mdat [2][8];
    logic [7:0] mraw [2], mblk [2], mbln [2];
    int         nd [2] = '{6, 4};
    int         bdiv [2] = '{4, 5};

    always #5 clk = ~clk;

    // k = number of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else k <= k + 1;
    end

    vdb_hex_display #(.DIGITS(6), .MUX_MODE(0), .ACTIVE_LOW(1), .SCAN_DIV(4), .BLINK_DIV(4)) u_static (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack_s), .rdata_o(rd_s), .hex_o(hex_s), .seg_o(seg_s), .dig_sel_o(sel_s));

    vdb_hex_display #(.DIGITS(4), .MUX_MODE(1), .ACTIVE_LOW(0), .SCAN_DIV(3), .BLINK_DIV(5)) u_mux (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack_m), .rdata_o(rd_m), .hex_o(hex_m), .seg_o(seg_m), .dig_sel_o(sel_m));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_rst();
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 8; n++) mdat[u][n] = 8'h00;
            mraw[u] = 8'h00;
            mblk[u] = 8'h00;
            mbln[u] = 8'((1 << nd[u]) - 1);
        end
    endfunction

    function automatic void model_wr(input int u, input int a, input logic [7:0] wd);
        logic [7:0] m;
        m = 8'((1 << nd[u]) - 1);
        if (a < nd[u]) mdat[u][a] = wd;
        else if (a == nd[u]) mraw[u] = wd & m;
        else if (a == nd[u] + 1) mblk[u] = wd & m;
        else if (a == nd[u] + 2) mbln[u] = wd & m;
    endfunction

    function automatic logic [7:0] model_rd(input int u, input int a);
        if (a < nd[u]) return mdat[u][a];
        if (a == nd[u]) return mraw[u];
        if (a == nd[u] + 1) return mblk[u];
        if (a == nd[u] + 2) return mbln[u];
        return 8'h00;
    endfunction

    // Active-high pattern shown for digit n on the edge after edge kk-1
    function automatic logic [7:0] vis_pat(input int u, input int n, input int kk);
        logic hid;
        hid = (((kk - 1) / bdiv[u]) % 2) != 0;
        if (mbln[u][n] || (mblk[u][n] && hid)) return 8'h00;
        return mraw[u][n] ? mdat[u][n] : {mdat[u][n][7], hex_tab[mdat[u][n][3:0]]};
    endfunction

    task automatic acc(input int u, input logic w, input int a, input logic [7:0] wd);
        @(negedge clk);
        we = w;
        addr = 4'(a);
        wdata = wd;
        req[u] = 1'b1;
        @(negedge clk);
        req[u] = 1'b0;
        chk($sformatf("ack%0d", u), 64'(u != 0 ? ack_m : ack_s), 64'd1);
        if (w) model_wr(u, a, wd);
        else chk($sformatf("rd%0d_a%0d", u, a), 64'(u != 0 ? rd_m : rd_s), 64'(model_rd(u, a)));
    endtask

    task automatic check_outputs(input int cycles);
        logic [47:0] eh;
        int p, i;
        logic drv;
        repeat (cycles) begin
            @(negedge clk);
            eh = '0;
            for (int n = 0; n < 6; n++) eh[8*n +: 8] = ~vis_pat(0, n, k);
            chk("hex_s", 64'(hex_s), 64'(eh));
            chk("seg_s", 64'(seg_s), 64'hFF);
            chk("sel_s", 64'(sel_s), 64'h3F);
            p = (k - 1) % 12;
            i = p / 3;
            drv = (p % 3) < 2;
            chk("sel_m", 64'(sel_m), drv ? 64'(1 << i) : 64'h0);
            chk("seg_m", 64'(seg_m), drv ? 64'(vis_pat(1, i, k)) : 64'h0);
            chk("hex_m", 64'(hex_m), 64'h0);
        end
    endtask

    initial begin
        logic found;
        req = 2'b00; we = 1'b0; addr = 4'h0; wdata = 8'h00;
        model_rst();
        rst_n = 1'b0;
        #12;
        chk("rst_ack_s", 64'(ack_s), 64'd0);
        chk("rst_rd_s", 64'(rd_s), 64'd0);
        chk("rst_hex_s", 64'(hex_s), 64'hFFFF_FFFF_FFFF);
        chk("rst_seg_s", 64'(seg_s), 64'hFF);
        chk("rst_sel_s", 64'(sel_s), 64'h3F);
        chk("rst_ack_m", 64'(ack_m), 64'd0);
        chk("rst_seg_m", 64'(seg_m), 64'h00);
        chk("rst_sel_m", 64'(sel_m), 64'h0);
        chk("rst_hex_m", 64'(hex_m), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        acc(0, 1, 8, 8'h00);
        acc(0, 1, 0, 8'h05);
        check_outputs(1);
        chk("hex_d0_5", 64'(hex_s[7:0]), 64'h92);
        chk("hex_d1_0", 64'(hex_s[15:8]), 64'hC0);

        acc(0, 1, 6, 8'h02);
        acc(0, 1, 1, 8'hAA);
        acc(0, 1, 2, 8'h8F);
        check_outputs(1);
        chk("raw_d1", 64'(hex_s[15:8]), 64'h55);
        chk("dp_d2", 64'(hex_s[23:16]), 64'h0E);
        acc(0, 0, 1, 8'h00);
        chk("rd_a1_lit", 64'(rd_s), 64'hAA);
        acc(0, 0, 12, 8'h00);
        acc(0, 1, 6, 8'hFF);
        acc(0, 0, 6, 8'h00);

        acc(0, 1, 6, 8'h00);
        acc(0, 1, 7, 8'h01);
        acc(0, 1, 0, 8'h00);
        check_outputs(16);

        acc(1, 1, 6, 8'h00);
        for (int i = 0; i < 4; i++) acc(1, 1, i, 8'(i + 1));
        check_outputs(24);

        @(negedge clk);
        we = 1'b1; addr = 4'd3; wdata = 8'h3C; req[0] = 1'b1;
        @(negedge clk);
        chk("b2b_ack1", 64'(ack_s), 64'd1);
        model_wr(0, 3, 8'h3C);
        wdata = 8'hC3;
        @(negedge clk);
        chk("b2b_ack2", 64'(ack_s), 64'd1);
        model_wr(0, 3, 8'hC3);
        we = 1'b0;
        @(negedge clk);
        req[0] = 1'b0;
        chk("b2b_ack3", 64'(ack_s), 64'd1);
        chk("b2b_rd", 64'(rd_s), 64'hC3);
        @(negedge clk);
        chk("b2b_ack_drop", 64'(ack_s), 64'd0);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 30; i++) begin
                int u;
                u = int'($urandom_range(0, 1));
                acc(u, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 8'($urandom));
            end
            check_outputs(30);
        end

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sel_m == 4'b0100) found = 1'b1;
        end
        chk("scan_idx2_seen", 64'(found), 64'd1);
        we = 1'b1; addr = 4'd0; wdata = 8'h55; req = 2'b11;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        req = 2'b00;
        model_rst();
        chk("arst_ack_s", 64'(ack_s), 64'd0);
        chk("arst_ack_m", 64'(ack_m), 64'd0);
        chk("arst_hex_s", 64'(hex_s), 64'hFFFF_FFFF_FFFF);
        chk("arst_seg_m", 64'(seg_m), 64'h00);
        chk("arst_sel_m", 64'(sel_m), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        check_outputs(14);
        acc(1, 0, 6, 8'h00);
        acc(1, 0, 0, 8'h00);
        acc(0, 0, 8, 8'h00);
        acc(0, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
